// File: rtl/mips_multicycle_cu.sv
// Multicycle MIPS main control FSM: walks fetch/decode/execute/memory/write-back
// and presents registered datapath strobes, mux selects and the ALUOp code.
module mips_multicycle_cu #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               JumpReg,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    JUMP   = 4'd9,
    IEX    = 4'd10,
    IWB    = 4'd11,
    JR     = 4'd12,
    ILL    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal;
    logic       done;
  } ctrl_t;

  // Control word presented while sitting in state s; op only matters in IEX.
  function automatic ctrl_t decode_ctrl(state_t s, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      MEMWB: begin
        c.reg_write = 1'b1;
        c.memto_reg = 1'b1;
        c.done      = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
        c.done      = 1'b1;
      end
      REX: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
      end
      RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b001;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.done          = 1'b1;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.done      = 1'b1;
      end
      IEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        if (op == OP_ANDI)     c.alu_op = 3'b011;
        else if (op == OP_ORI) c.alu_op = 3'b100;
        else                   c.alu_op = 3'b000;
      end
      IWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b11;
        c.done      = 1'b1;
      end
      ILL: begin
        c.illegal = 1'b1;
        c.done    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state_reg, state_next;
  logic [5:0] op_reg, op_next;
  ctrl_t      ctrl_reg, ctrl_out;

  always_comb begin
    state_next = FETCH;
    op_next    = (state_reg == DECODE) ? opcode : op_reg;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:                  state_next = REX;
          OP_LW, OP_SW:              state_next = MEMADR;
          OP_BEQ:                    state_next = BEQ;
          OP_J:                      state_next = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  state_next = IEX;
          default:                   state_next = ILL;
        endcase
      end
      MEMADR: state_next = (op_reg == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      REX:    state_next = JumpReg ? JR : RWB;
      IEX:    state_next = IWB;
      default: state_next = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      op_reg    <= '0;
      ctrl_reg  <= decode_ctrl(FETCH, '0);
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      ctrl_reg  <= decode_ctrl(state_next, op_next);
    end
  end

  // Holding reset silences every strobe and select, even before the first edge.
  assign ctrl_out = reset ? '0 : ctrl_reg;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.ior_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign MemtoReg    = ctrl_out.memto_reg;
  assign IRWrite     = ctrl_out.ir_write;
  assign PCSource    = ctrl_out.pc_source;
  assign ALUOp       = ctrl_out.alu_op;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign RegWrite    = ctrl_out.reg_write;
  assign RegDst      = ctrl_out.reg_dst;
  assign illegal_op  = ctrl_out.illegal;
  assign instr_done  = ctrl_out.done;
  assign state       = STATE_W'(state_reg);

endmodule

// File: tb/tb_mips_multicycle_cu.sv
// Bench for mips_multicycle_cu: expected state/control words are queued per
// instruction and popped one per cycle against the DUT.
module tb_mips_multicycle_cu;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       JumpReg;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite, RegDst, illegal_op, instr_done;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  exp_state_q[$];
  logic [18:0] exp_ctrl_q[$];

  mips_multicycle_cu #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .JumpReg(JumpReg),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal_op(illegal_op), .instr_done(instr_done),
    .state(state)
  );

  always #5 clk = ~clk;

  wire [18:0] dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                          IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
                          RegDst, illegal_op, instr_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference control table, field order matches dut_ctrl.
  function automatic logic [18:0] exp_ctrl(input int s, input logic [5:0] op);
    logic pw, pwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill, done;
    logic [1:0] pcs, asb;
    logic [2:0] aop;
    {pw, pwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill, done} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 3'b000;
    case (s)
      0:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iord = 1; done = 1; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin asa = 1; aop = 3'b001; pwc = 1; pcs = 2'b01; done = 1; end
      9:  begin pw = 1; pcs = 2'b10; done = 1; end
      10: begin
        asa = 1; asb = 2'b10;
        aop = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b100 : 3'b000;
      end
      11: begin rw = 1; done = 1; end
      12: begin pw = 1; pcs = 2'b11; done = 1; end
      13: begin ill = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, m2r, irw, pcs, aop, asa, asb, rw, rd, ill, done};
  endfunction

  task automatic push(input int s, input logic [18:0] c);
    exp_state_q.push_back(s[3:0]);
    exp_ctrl_q.push_back(c);
  endtask

  task automatic push_instr(input logic [5:0] op, input logic jr);
    push(0, exp_ctrl(0, op));
    push(1, exp_ctrl(1, op));
    case (op)
      6'h23: begin push(2, exp_ctrl(2, op)); push(3, exp_ctrl(3, op)); push(4, exp_ctrl(4, op)); end
      6'h2B: begin push(2, exp_ctrl(2, op)); push(5, exp_ctrl(5, op)); end
      6'h00: begin push(6, exp_ctrl(6, op)); push(jr ? 12 : 7, exp_ctrl(jr ? 12 : 7, op)); end
      6'h04: push(8, exp_ctrl(8, op));
      6'h02: push(9, exp_ctrl(9, op));
      6'h08, 6'h0C, 6'h0D: begin push(10, exp_ctrl(10, op)); push(11, exp_ctrl(11, op)); end
      default: push(13, exp_ctrl(13, op));
    endcase
  endtask

  // Pops one expected cycle, compares, returns the expected state for driving.
  task automatic check_pop(input string tag, output int s);
    logic [3:0]  es;
    logic [18:0] ec;
    if (exp_state_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
      s = 0;
      return;
    end
    es = exp_state_q.pop_front();
    ec = exp_ctrl_q.pop_front();
    s = int'(es);
    check({tag, "_state"}, 32'(state), 32'(es));
    check({tag, "_ctrl"}, 32'(dut_ctrl), 32'(ec));
    $display("%s: state=%0d ctrl=%h (exp state=%0d ctrl=%h)", tag, state, dut_ctrl, es, ec);
  endtask

  task automatic drive(input int s, input logic [5:0] op, input logic [5:0] op_after,
                       input logic jr_rex, input logic jr_other);
    opcode  = (s <= 1) ? op : op_after;
    JumpReg = (s == 6) ? jr_rex : jr_other;
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] op_after,
                           input logic jr_rex, input logic jr_other);
    int n, s;
    push_instr(op, jr_rex);
    n = exp_state_q.size();
    repeat (n) begin
      check_pop(tag, s);
      drive(s, op, op_after, jr_rex, jr_other);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int s;
    reset = 1'b1; opcode = 6'h00; JumpReg = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      push(0, 19'h0);
      check_pop("rst_hold", s);
    end
    reset = 1'b0; #1;

    run_instr("lw",   6'h23, 6'h23, 1'b0, 1'b0);
    run_instr("sw",   6'h2B, 6'h2B, 1'b0, 1'b0);
    run_instr("rtyp", 6'h00, 6'h00, 1'b0, 1'b0);
    run_instr("jr",   6'h00, 6'h00, 1'b1, 1'b0);
    run_instr("addi", 6'h08, 6'h08, 1'b0, 1'b0);
    run_instr("andi", 6'h0C, 6'h04, 1'b0, 1'b0);
    run_instr("ori",  6'h0D, 6'h04, 1'b0, 1'b0);
    run_instr("beq",  6'h04, 6'h04, 1'b0, 1'b0);
    run_instr("j",    6'h02, 6'h02, 1'b0, 1'b0);
    run_instr("ill",  6'h3F, 6'h3F, 1'b1, 1'b1);
    run_instr("ill01",6'h01, 6'h01, 1'b1, 1'b1);
    run_instr("lw_jr",6'h23, 6'h23, 1'b1, 1'b1);
    run_instr("r_jro",6'h00, 6'h00, 1'b0, 1'b1);

    // lw abandoned in MEMRD by a 3-cycle reset
    push_instr(6'h23, 1'b0);
    repeat (4) begin
      check_pop("lw_cut", s);
      drive(s, 6'h23, 6'h23, 1'b0, 1'b0);
      if (s != 3) begin @(posedge clk); #1; end
    end
    exp_state_q.delete(); exp_ctrl_q.delete();
    reset = 1'b1; #1;
    push(3, 19'h0);
    check_pop("rst_mid", s);
    repeat (3) begin
      @(posedge clk); #1;
      push(0, 19'h0);
      check_pop("rst_mid", s);
    end
    reset = 1'b0; #1;
    run_instr("post_rst", 6'h23, 6'h23, 1'b0, 1'b0);
    run_instr("beq2",     6'h04, 6'h04, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
